mfp_adc_max10_seq: RTL and testbench

- Parametrised successor to the MAX10 ADC register/sequencer core.
- Scans a configurable set of ADC cells as one Avalon-ST command packet per scan.
- Averages 2^N scans per cell in hardware and commits the results atomically.
- Adds trigger edge detection, an overrun flag and a busy flag; sits between the AHB-Lite register front-end and the Altera MAX10 ADC IP.

---
 rtl/mfp_adc_max10_seq.sv | 190 +++++++++++++++++++
 tb/tb_mfp_adc_max10_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_adc_max10_seq.sv
// MAX10 ADC sequencer: scans masked cells as one Avalon-ST command packet per scan,
// averages 2^N scans per cell and commits the results atomically.
module mfp_adc_max10_seq #(
  parameter int unsigned CELL_COUNT   = 8,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned AVG_LOG2_MAX = 4,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter logic [79:0] CHANNEL_MAP  = {16{5'd0}}
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  output logic                  ADC_C_Valid,
  output logic                  ADC_C_SOP,
  output logic                  ADC_C_EOP,
  output logic [4:0]            ADC_C_Channel,
  input  logic                  ADC_C_Ready,
  input  logic                  ADC_R_Valid,
  input  logic                  ADC_R_SOP,
  input  logic                  ADC_R_EOP,
  input  logic [4:0]            ADC_R_Channel,
  input  logic [DATA_WIDTH-1:0] ADC_R_Data,
  input  logic                  ADC_Trigger,
  output logic                  ADC_Interrupt
);
  localparam int unsigned AW = DATA_WIDTH + AVG_LOG2_MAX;
  localparam int unsigned SW = AVG_LOG2_MAX + 1;

  typedef enum logic [2:0] {IDLE, FIRST, NEXT, LAST, SINGLE, WAIT, COMMIT} state_t;
  state_t state;

  logic                  en, sc, te, fr, ie, irq_flag, ov;
  logic                  en_d, sc_d, te_d, fr_d, ie_d, irq_d, ov_d;
  logic [CELL_COUNT-1:0] mask, smask, launch_mask;
  logic [2:0]            avg_n, sn;
  logic [SW-1:0]         scan, scan_max;
  logic [3:0]            cur, first_idx, next_idx;
  logic                  trig_prev, trig_edge, busy, wr_ctl;
  logic                  start_req, wait_done, last_scan, launch, launch_live, sc_clr;
  logic                  first_single, next_more;
  logic [AW-1:0]         acc    [CELL_COUNT];
  logic [DATA_WIDTH-1:0] result [CELL_COUNT];
  logic                  unused_bits;

  function automatic logic [4:0] chan_of(input logic [3:0] idx);
    return CHANNEL_MAP[5*int'(idx) +: 5];
  endfunction

  function automatic logic [3:0] lowest_from(input logic [CELL_COUNT-1:0] m, input int unsigned from);
    lowest_from = '0;
    for (int unsigned i = CELL_COUNT; i > 0; i--)
      if (i - 1 >= from && m[i-1]) lowest_from = 4'(i - 1);
  endfunction

  function automatic logic any_from(input logic [CELL_COUNT-1:0] m, input int unsigned from);
    any_from = 1'b0;
    for (int unsigned i = 0; i < CELL_COUNT; i++)
      if (i >= from && m[i]) any_from = 1'b1;
  endfunction

  assign unused_bits   = ^{ADC_R_SOP, write_data[31:8]};
  assign ADC_Interrupt = irq_flag;
  assign busy          = (state != IDLE);
  assign wr_ctl        = write_enable && (write_addr == ADDR_WIDTH'(0));
  assign trig_edge     = ADC_Trigger & ~trig_prev;
  assign start_req     = (state == IDLE) && en && (sc || (te && trig_edge));
  assign wait_done     = (state == WAIT) && ADC_R_Valid && ADC_R_EOP;
  assign scan_max      = SW'((32'd1 << sn) - 32'd1);
  assign last_scan     = (scan == scan_max);

  // A launch either re-latches the live config (new run) or rescans with the shadow copy.
  assign launch_live  = (start_req || ((state == COMMIT) && fr && en)) && (mask != '0);
  assign launch       = launch_live || (wait_done && en && !last_scan);
  assign launch_mask  = launch_live ? mask : smask;
  assign first_idx    = lowest_from(launch_mask, 0);
  assign first_single = !any_from(launch_mask, 32'(first_idx) + 32'd1);
  assign next_idx     = lowest_from(smask, 32'(cur) + 32'd1);
  assign next_more    = any_from(smask, 32'(next_idx) + 32'd1);
  assign sc_clr       = (start_req && (mask == '0)) || ((state == COMMIT) && !fr) || (wait_done && !en);

  always_comb begin
    en_d = en;
    sc_d = sc;
    te_d = te;
    fr_d = fr;
    ie_d = ie;
    if (wr_ctl) begin
      en_d = write_data[0];
      if (!(busy && write_data[1])) sc_d = write_data[1];
      te_d = write_data[2];
      fr_d = write_data[3];
      ie_d = write_data[4];
    end
    if (sc_clr) sc_d = 1'b0;
    // Hardware set beats a same-cycle write-1-clear; IF is forced low while disabled.
    irq_d = ((state == COMMIT) && ie) || (irq_flag && !(wr_ctl && write_data[5]));
    if (!en_d) irq_d = 1'b0;
    ov_d = (busy && ((wr_ctl && write_data[1]) || (en && te && trig_edge)))
        || (ov && !(wr_ctl && write_data[6]));
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      en <= 1'b0; sc <= 1'b0; te <= 1'b0; fr <= 1'b0; ie <= 1'b0;
      irq_flag <= 1'b0; ov <= 1'b0; trig_prev <= 1'b0;
      mask <= '0; avg_n <= '0;
    end else begin
      en <= en_d; sc <= sc_d; te <= te_d; fr <= fr_d; ie <= ie_d;
      irq_flag <= irq_d; ov <= ov_d; trig_prev <= ADC_Trigger;
      if (write_enable && write_addr == ADDR_WIDTH'(1)) mask <= write_data[CELL_COUNT-1:0];
      if (write_enable && write_addr == ADDR_WIDTH'(2))
        avg_n <= (write_data[2:0] > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : write_data[2:0];
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE; smask <= '0; sn <= '0; scan <= '0; cur <= '0;
      ADC_C_Valid <= 1'b0; ADC_C_SOP <= 1'b0; ADC_C_EOP <= 1'b0; ADC_C_Channel <= '0;
    end else if (launch) begin
      state         <= first_single ? SINGLE : FIRST;
      cur           <= first_idx;
      ADC_C_Valid   <= 1'b1;
      ADC_C_SOP     <= 1'b1;
      ADC_C_EOP     <= first_single;
      ADC_C_Channel <= chan_of(first_idx);
      if (launch_live) begin
        smask <= mask;
        sn    <= avg_n;
        scan  <= '0;
      end else begin
        scan <= scan + SW'(1);
      end
    end else begin
      case (state)
        FIRST, NEXT: if (ADC_C_Ready) begin
          cur           <= next_idx;
          state         <= next_more ? NEXT : LAST;
          ADC_C_SOP     <= 1'b0;
          ADC_C_EOP     <= !next_more;
          ADC_C_Channel <= chan_of(next_idx);
        end
        LAST, SINGLE: if (ADC_C_Ready) begin
          state         <= WAIT;
          ADC_C_Valid   <= 1'b0;
          ADC_C_SOP     <= 1'b0;
          ADC_C_EOP     <= 1'b0;
          ADC_C_Channel <= '0;
        end
        // Only the final scan (or a disabled block) reaches here without relaunching.
        WAIT:    if (wait_done) state <= en ? COMMIT : IDLE;
        COMMIT:  state <= IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int unsigned i = 0; i < CELL_COUNT; i++) begin
        acc[i]    <= '0;
        result[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CELL_COUNT; i++) begin
        if (busy && ADC_R_Valid && smask[i] && ADC_R_Channel == chan_of(4'(i)))
          acc[i] <= (scan == '0) ? AW'(ADC_R_Data) : acc[i] + AW'(ADC_R_Data);
        if (state == COMMIT && smask[i])
          result[i] <= DATA_WIDTH'(acc[i] >> sn);
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (read_addr == ADDR_WIDTH'(0))
      read_data = {24'd0, busy, ov, irq_flag, ie, fr, te, sc, en};
    else if (read_addr == ADDR_WIDTH'(1))
      read_data = 32'(mask);
    else if (read_addr == ADDR_WIDTH'(2))
      read_data = {29'd0, avg_n};
    for (int unsigned i = 0; i < CELL_COUNT; i++)
      if (read_addr == ADDR_WIDTH'(16 + i)) read_data = 32'(result[i]);
  end

endmodule

// File: tb/tb_mfp_adc_max10_seq.sv
// Bench for mfp_adc_max10_seq: an ADC IP responder with randomized samples and a
// per-cell sum/shift reference model of the averaged results.
module tb_mfp_adc_max10_seq;
  localparam logic [79:0] MAP = {5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,
                                 5'd8,  5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1};

  logic        CLK, RESETn;
  logic [4:0]  read_addr, write_addr;
  logic [31:0] read_data, write_data;
  logic        write_enable;
  logic        c_valid, c_sop, c_eop, c_ready;
  logic [4:0]  c_channel;
  logic        r_valid, r_sop, r_eop;
  logic [4:0]  r_channel;
  logic [11:0] r_data;
  logic        trigger, irq;

  mfp_adc_max10_seq #(.CELL_COUNT(8), .DATA_WIDTH(12), .AVG_LOG2_MAX(4), .ADDR_WIDTH(5),
                      .CHANNEL_MAP(MAP)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .ADC_C_Valid(c_valid), .ADC_C_SOP(c_sop), .ADC_C_EOP(c_eop),
    .ADC_C_Channel(c_channel), .ADC_C_Ready(c_ready),
    .ADC_R_Valid(r_valid), .ADC_R_SOP(r_sop), .ADC_R_EOP(r_eop),
    .ADC_R_Channel(r_channel), .ADC_R_Data(r_data),
    .ADC_Trigger(trigger), .ADC_Interrupt(irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  int          pkt_n;
  logic [4:0]  pkt_ch [16];
  logic [2:0]  pkt_fl [16];
  bit          pkt_stable, pkt_ok;
  logic [11:0] samp [16];
  bit          use_pre;
  int          sums [8];
  int          exp_res [8];

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    write_addr = a; write_data = d; write_enable = 1'b1;
    @(negedge CLK);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge CLK);
    read_addr = a;
    #1 d = read_data;
  endtask

  // Acts as the ADC IP command sink; optionally withholds Ready on one beat.
  task automatic collect_packet(input int stall_beat, input int stall_len);
    int stalled = 0;
    logic [7:0] snap = '0;
    pkt_n = 0; pkt_ok = 1'b0; pkt_stable = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge CLK);
      if (!c_valid) begin c_ready = 1'b0; continue; end
      if (pkt_n == stall_beat && stalled < stall_len) begin
        if (stalled == 0) snap = {c_valid, c_sop, c_eop, c_channel};
        else if (snap !== {c_valid, c_sop, c_eop, c_channel}) pkt_stable = 1'b0;
        c_ready = 1'b0;
        stalled++;
        continue;
      end
      if (stalled > 0 && pkt_n == stall_beat && snap !== {c_valid, c_sop, c_eop, c_channel})
        pkt_stable = 1'b0;
      if (pkt_n < 16) begin
        pkt_ch[pkt_n] = c_channel;
        pkt_fl[pkt_n] = {c_valid, c_sop, c_eop};
      end
      pkt_n++;
      c_ready = 1'b1;
      if (c_eop) begin pkt_ok = 1'b1; break; end
    end
    @(negedge CLK);
    c_ready = 1'b0;
  endtask

  // Answers the last packet channel by channel; model sums by channel-to-cell lookup.
  task automatic send_resp(input logic [7:0] m);
    for (int k = 0; k < pkt_n && k < 16; k++) begin
      @(negedge CLK);
      if (!use_pre) samp[k] = 12'($urandom_range(0, 4095));
      r_valid = 1'b1; r_sop = (k == 0); r_eop = (k == pkt_n - 1);
      r_channel = pkt_ch[k]; r_data = samp[k];
      if (int'(pkt_ch[k]) >= 1 && int'(pkt_ch[k]) <= 8 && m[int'(pkt_ch[k]) - 1])
        sums[int'(pkt_ch[k]) - 1] += int'(samp[k]);
    end
    @(negedge CLK);
    r_valid = 1'b0; r_sop = 1'b0; r_eop = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rd(5'd0, d);
      if (!d[7]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (c_valid) n++;
    end
  endtask

  function automatic int exp_cells(input logic [7:0] m, output int cells [8]);
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i]) begin cells[n] = i; n++; end
    return n;
  endfunction

  function automatic logic [2:0] exp_flag(input int k, input int n);
    if (n == 1) return 3'b111;
    if (k == 0) return 3'b110;
    if (k == n - 1) return 3'b101;
    return 3'b100;
  endfunction

  task automatic commit_model(input logic [7:0] m, input int n);
    for (int i = 0; i < 8; i++) if (m[i]) exp_res[i] = sums[i] >> n;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    total++; if ({c_valid, c_sop, c_eop, c_channel, irq} !== 9'd0)
      $display("FAIL reset_outputs got %b exp 0", {c_valid, c_sop, c_eop, c_channel, irq}); else passed++;
    for (int a = 0; a < 3; a++) begin
      rd(5'(a), d);
      total++; if (d !== 32'd0) $display("FAIL reset_reg%0d got %h exp 0", a, d); else passed++;
    end
    for (int i = 0; i < 8; i++) begin
      rd(5'(16 + i), d);
      total++; if (d !== 32'd0) $display("FAIL reset_res%0d got %h exp 0", i, d); else passed++;
      exp_res[i] = 0;
    end
  endtask

  task automatic test_basic;
    logic [31:0] d; bit ok;
    wr(5'd1, 32'h05); wr(5'd2, 32'h0);
    sums = '{default: 0};
    use_pre = 1'b1; samp[0] = 12'h123; samp[1] = 12'hABC;
    wr(5'd0, 32'h03);
    collect_packet(-1, 0);
    total++; if (!pkt_ok || pkt_n != 2) $display("FAIL basic_beats got ok=%0d n=%0d exp ok=1 n=2", pkt_ok, pkt_n); else passed++;
    total++; if ({pkt_ch[0], pkt_fl[0]} !== {5'd1, 3'b110})
      $display("FAIL basic_beat0 got ch=%0d fl=%b exp ch=1 fl=110", pkt_ch[0], pkt_fl[0]); else passed++;
    total++; if ({pkt_ch[1], pkt_fl[1]} !== {5'd3, 3'b101})
      $display("FAIL basic_beat1 got ch=%0d fl=%b exp ch=3 fl=101", pkt_ch[1], pkt_fl[1]); else passed++;
    send_resp(8'h05);
    wait_idle(ok);
    total++; if (!ok) $display("FAIL basic_idle got busy exp idle"); else passed++;
    commit_model(8'h05, 0);
    rd(5'd16, d); total++; if (d !== 32'h123) $display("FAIL basic_r16 got %h exp 123", d); else passed++;
    rd(5'd18, d); total++; if (d !== 32'hABC) $display("FAIL basic_r18 got %h exp abc", d); else passed++;
    rd(5'd17, d); total++; if (d !== 32'(exp_res[1])) $display("FAIL basic_r17 got %h exp %h", d, exp_res[1]); else passed++;
    rd(5'd0, d); total++; if (d !== 32'h01) $display("FAIL basic_adcs got %h exp 01", d); else passed++;
    use_pre = 1'b0;
  endtask

  task automatic test_average;
    logic [31:0] d; bit ok, good;
    int vals [4] = '{100, 101, 102, 104};
    int cells [8]; int nc; logic [7:0] m; int n;
    wr(5'd2, 32'h7); rd(5'd2, d);
    total++; if (d !== 32'd4) $display("FAIL avg_clamp got %0d exp 4", d); else passed++;
    wr(5'd1, 32'h02); wr(5'd2, 32'h2);
    sums = '{default: 0};
    use_pre = 1'b1;
    wr(5'd0, 32'h13);
    for (int s = 0; s < 4; s++) begin
      samp[0] = 12'(vals[s]);
      collect_packet(-1, 0);
      total++; if (!pkt_ok || pkt_n != 1 || {pkt_ch[0], pkt_fl[0]} !== {5'd2, 3'b111})
        $display("FAIL avg_single%0d got n=%0d ch=%0d fl=%b exp n=1 ch=2 fl=111", s, pkt_n, pkt_ch[0], pkt_fl[0]); else passed++;
      send_resp(8'h02);
    end
    wait_idle(ok);
    commit_model(8'h02, 2);
    rd(5'd17, d); total++; if (d !== 32'd101) $display("FAIL avg_r17 got %0d exp 101", d); else passed++;
    rd(5'd0, d); total++; if (d[5] !== 1'b1 || irq !== 1'b1) $display("FAIL avg_if got if=%b irq=%b exp 1", d[5], irq); else passed++;
    wr(5'd0, 32'h31); rd(5'd0, d);
    total++; if (d !== 32'h11 || irq !== 1'b0) $display("FAIL avg_if_clear got %h irq=%b exp 11", d, irq); else passed++;
    use_pre = 1'b0;
    repeat (3) begin
      m = 8'($urandom_range(1, 255)); n = int'($urandom_range(0, 4));
      nc = exp_cells(m, cells);
      wr(5'd1, 32'(m)); wr(5'd2, 32'(n));
      sums = '{default: 0};
      wr(5'd0, 32'h03);
      good = 1'b1;
      for (int s = 0; s < (1 << n); s++) begin
        collect_packet(-1, 0);
        if (!pkt_ok || pkt_n != nc) good = 1'b0;
        for (int k = 0; k < nc && k < pkt_n; k++)
          if (pkt_ch[k] !== 5'(cells[k] + 1) || pkt_fl[k] !== exp_flag(k, nc)) good = 1'b0;
        send_resp(m);
      end
      total++; if (!good) $display("FAIL rand_beats got wrong beats exp mask=%h scans=%0d", m, 1 << n); else passed++;
      wait_idle(ok);
      commit_model(m, n);
      for (int i = 0; i < 8; i++) begin
        rd(5'(16 + i), d);
        total++; if (d !== 32'(exp_res[i])) $display("FAIL rand_res%0d got %h exp %h", i, d, exp_res[i]); else passed++;
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] d; bit ok;
    wr(5'd1, 32'h0E); wr(5'd2, 32'h0);
    sums = '{default: 0};
    wr(5'd0, 32'h03);
    collect_packet(1, 5);
    total++; if (!pkt_stable) $display("FAIL stall_stable got unstable exp stable"); else passed++;
    total++; if (!pkt_ok || pkt_n != 3 || pkt_ch[0] !== 5'd2 || pkt_ch[1] !== 5'd3 || pkt_ch[2] !== 5'd4)
      $display("FAIL stall_chans got n=%0d %0d,%0d,%0d exp 3 2,3,4", pkt_n, pkt_ch[0], pkt_ch[1], pkt_ch[2]); else passed++;
    total++; if ({pkt_fl[0], pkt_fl[1], pkt_fl[2]} !== 9'b110_100_101)
      $display("FAIL stall_flags got %b %b %b exp 110 100 101", pkt_fl[0], pkt_fl[1], pkt_fl[2]); else passed++;
    send_resp(8'h0E);
    wait_idle(ok);
    commit_model(8'h0E, 0);
    for (int i = 1; i < 4; i++) begin
      rd(5'(16 + i), d);
      total++; if (d !== 32'(exp_res[i])) $display("FAIL stall_res%0d got %h exp %h", i, d, exp_res[i]); else passed++;
    end
  endtask

  task automatic test_trigger;
    logic [31:0] d; bit ok; int extra;
    wr(5'd1, 32'h01); wr(5'd2, 32'h0);
    sums = '{default: 0};
    wr(5'd0, 32'h05);
    @(negedge CLK); trigger = 1'b1;
    collect_packet(-1, 0);
    send_resp(8'h01);
    count_valid(8, extra);
    trigger = 1'b0;
    total++; if (!pkt_ok || pkt_n != 1 || extra != 0)
      $display("FAIL trig_one_scan got ok=%0d n=%0d extra=%0d exp 1 1 0", pkt_ok, pkt_n, extra); else passed++;
    wait_idle(ok);
    commit_model(8'h01, 0);
    rd(5'd16, d); total++; if (d !== 32'(exp_res[0])) $display("FAIL trig_res got %h exp %h", d, exp_res[0]); else passed++;
    rd(5'd0, d);  total++; if (d !== 32'h05) $display("FAIL trig_adcs got %h exp 05", d); else passed++;
    sums = '{default: 0};
    @(negedge CLK); trigger = 1'b1;
    @(negedge CLK); trigger = 1'b0;
    @(negedge CLK); trigger = 1'b1;
    @(negedge CLK); trigger = 1'b0;
    collect_packet(-1, 0);
    send_resp(8'h01);
    wait_idle(ok);
    count_valid(10, extra);
    total++; if (extra != 0) $display("FAIL trig_no_extra got %0d exp 0", extra); else passed++;
    rd(5'd0, d); total++; if (d !== 32'h45) $display("FAIL trig_ov_set got %h exp 45", d); else passed++;
    wr(5'd0, 32'h45); rd(5'd0, d);
    total++; if (d !== 32'h05) $display("FAIL trig_ov_clear got %h exp 05", d); else passed++;
    wr(5'd0, 32'h0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; bit ok; int extra;
    wr(5'd1, 32'h03); wr(5'd2, 32'h0);
    sums = '{default: 0};
    wr(5'd0, 32'h1B);
    collect_packet(-1, 0);
    send_resp(8'h03);
    @(negedge CLK);
    total++; if ({c_valid, c_sop, c_eop} !== 3'b110)
      $display("FAIL fr_restart got %b exp 110", {c_valid, c_sop, c_eop}); else passed++;
    commit_model(8'h03, 0);
    rd(5'd16, d); total++; if (d !== 32'(exp_res[0])) $display("FAIL fr_r16 got %h exp %h", d, exp_res[0]); else passed++;
    rd(5'd17, d); total++; if (d !== 32'(exp_res[1])) $display("FAIL fr_r17 got %h exp %h", d, exp_res[1]); else passed++;
    rd(5'd0, d);  total++; if (d[5] !== 1'b1) $display("FAIL fr_if got %b exp 1", d[5]); else passed++;
    wr(5'd0, 32'h08);
    collect_packet(-1, 0);
    total++; if (!pkt_ok || pkt_n != 2 || pkt_fl[1] !== 3'b101)
      $display("FAIL fr_abort_pkt got ok=%0d n=%0d fl=%b exp 1 2 101", pkt_ok, pkt_n, pkt_fl[1]); else passed++;
    sums = '{default: 0};
    send_resp(8'h03);
    wait_idle(ok);
    count_valid(10, extra);
    total++; if (!ok || extra != 0) $display("FAIL fr_abort_idle got ok=%0d extra=%0d exp 1 0", ok, extra); else passed++;
    rd(5'd16, d); total++; if (d !== 32'(exp_res[0])) $display("FAIL fr_nocommit16 got %h exp %h", d, exp_res[0]); else passed++;
    rd(5'd17, d); total++; if (d !== 32'(exp_res[1])) $display("FAIL fr_nocommit17 got %h exp %h", d, exp_res[1]); else passed++;
    rd(5'd0, d);  total++; if (d !== 32'h08 || irq !== 1'b0) $display("FAIL fr_adcs got %h irq=%b exp 08 0", d, irq); else passed++;
    wr(5'd0, 32'h0);
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d; bit seen = 1'b0;
    wr(5'd1, 32'h01); wr(5'd2, 32'h0);
    wr(5'd0, 32'h03);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (c_valid) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL rst_wait_valid got timeout exp valid"); else passed++;
    #2 RESETn = 1'b0;
    #1;
    total++; if ({c_valid, c_sop, c_eop, c_channel, irq} !== 9'd0)
      $display("FAIL rst_async got %b exp 0", {c_valid, c_sop, c_eop, c_channel, irq}); else passed++;
    @(negedge CLK); RESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(5'(16 + i), d);
      total++; if (d !== 32'd0) $display("FAIL rst_res%0d got %h exp 0", i, d); else passed++;
    end
    rd(5'd0, d); total++; if (d !== 32'd0) $display("FAIL rst_adcs got %h exp 0", d); else passed++;
  endtask

  initial begin
    RESETn = 1'b0; read_addr = '0; write_addr = '0; write_data = '0; write_enable = 1'b0;
    c_ready = 1'b0; r_valid = 1'b0; r_sop = 1'b0; r_eop = 1'b0; r_channel = '0; r_data = '0;
    trigger = 1'b0; use_pre = 1'b0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    test_reset;
    test_basic;
    test_average;
    test_stall;
    test_trigger;
    test_back_to_back;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got stuck exp finish");
    $fatal(1, "timeout");
  end
endmodule
